// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for a simple in-order core: steps each instruction
// through FETCH/DECODE/EXECUTE/MEM/WB, drives datapath strobes and counts retirements.
module core_sequencer #(
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [2:0]           i_inst_type,
  input  logic [4:0]           i_rd,
  input  logic                 i_branch_taken,
  input  logic                 i_imem_ack,
  input  logic                 i_dmem_ack,
  output logic                 o_imem_req,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic                 o_ir_we,
  output logic                 o_rf_we,
  output logic                 o_pc_we,
  output logic                 o_pc_sel,
  output logic                 o_halted,
  output logic [2:0]           o_state,
  output logic [INSTRET_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [2:0] T_LOAD   = 3'd2;
  localparam logic [2:0] T_STORE  = 3'd3;
  localparam logic [2:0] T_BRANCH = 3'd4;
  localparam logic [2:0] T_JUMP   = 3'd6;
  localparam logic [2:0] T_SYSTEM = 3'd7;

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_t                 r_state;
  logic   [2:0]           r_type_q;
  logic   [4:0]           r_rd_q;
  logic   [INSTRET_W-1:0] r_instret;

  state_t w_next;
  logic   w_imem_req;
  logic   w_dmem_req;
  logic   w_dmem_we;
  logic   w_ir_we;
  logic   w_rf_we;
  logic   w_pc_we;
  logic   w_pc_sel;
  logic   w_halted;
  logic   w_retire;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_type_q  <= 3'd0;
      r_rd_q    <= 5'd0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_type_q <= i_inst_type;
        r_rd_q   <= i_rd;
      end
      if (w_retire) begin
        r_instret <= r_instret + INSTRET_ONE;
      end
    end
  end

  // Requests depend only on r_state/r_type_q; acks only steer strobes and next state.
  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_ir_we    = 1'b0;
    w_rf_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    w_halted   = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = (i_inst_type == T_SYSTEM) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (r_type_q)
          T_LOAD, T_STORE: w_next = S_MEM;
          T_BRANCH: begin
            w_pc_we  = 1'b1;
            w_pc_sel = i_branch_taken;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          T_SYSTEM: w_next = S_HALT;
          default:  w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_type_q == T_STORE);
        if (i_dmem_ack) begin
          if (r_type_q == T_STORE) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we  = (r_rd_q != 5'd0);
        w_pc_we  = 1'b1;
        w_pc_sel = (r_type_q == T_JUMP);
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Everything is forced quiet while reset is held, including the cycle of the reset edge.
  assign o_imem_req = w_imem_req & i_rst_n;
  assign o_dmem_req = w_dmem_req & i_rst_n;
  assign o_dmem_we  = w_dmem_we  & i_rst_n;
  assign o_ir_we    = w_ir_we    & i_rst_n;
  assign o_rf_we    = w_rf_we    & i_rst_n;
  assign o_pc_we    = w_pc_we    & i_rst_n;
  assign o_pc_sel   = w_pc_sel   & i_rst_n;
  assign o_halted   = w_halted   & i_rst_n;
  assign o_state    = r_state;
  assign o_instret  = r_instret;

endmodule
